// File: rtl/extmem_bridge.sv
// Bridge from the inverted_residual_block external-memory port to a single-port sync SRAM.
// Client accesses take priority over host accesses. Reads return in issue order after MEM_LAT+2 edges.
module extmem_bridge #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 26,
    parameter int MEM_WORDS = 48 * (2 ** 20),
    parameter int OFF_FMO   = 4 * (2 ** 20),
    parameter int OFF_KEX   = 6 * (2 ** 20),
    parameter int MEM_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              request_extmem,
    input  logic              write_extmem,
    input  logic [31:0]       addr_extmem,
    input  logic [DATA_W-1:0] w_data,
    output logic              valid_extmem,
    output logic [DATA_W-1:0] data_extmem,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ready,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err_rd,
    output logic              err_wr,
    output logic [31:0]       rd_cnt,
    output logic [31:0]       wr_cnt
);

    typedef struct packed {
        logic vld;
        logic host;
        logic zero;
    } rsp_t;

    rsp_t              iss;
    rsp_t              pipe [0:MEM_LAT];
    logic              c_in_range;
    logic              c_wr_ok;
    logic              h_in_range;
    logic [DATA_W-1:0] rsp_data;

    always_comb begin
        host_ready = rst & host_req & ~request_extmem;
        c_in_range = addr_extmem < 32'(MEM_WORDS);
        c_wr_ok    = c_in_range && (addr_extmem >= 32'(OFF_FMO)) && (addr_extmem < 32'(OFF_KEX));
        h_in_range = 32'(host_addr) < 32'(MEM_WORDS);
        rsp_data   = pipe[MEM_LAT].zero ? '0 : mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            valid_extmem <= 1'b0;
            data_extmem  <= '0;
            host_rvalid  <= 1'b0;
            host_rdata   <= '0;
            err_rd       <= 1'b0;
            err_wr       <= 1'b0;
            rd_cnt       <= '0;
            wr_cnt       <= '0;
            iss          <= '0;
            for (int i = 0; i <= MEM_LAT; i++) pipe[i] <= '0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            iss    <= '0;
            if (request_extmem) begin
                mem_addr  <= addr_extmem[ADDR_W-1:0];
                mem_wdata <= w_data;
                if (write_extmem) begin
                    wr_cnt <= wr_cnt + 32'd1;
                    mem_en <= c_wr_ok;
                    mem_we <= c_wr_ok;
                    if (!c_wr_ok) err_wr <= 1'b1;
                end else begin
                    // Out-of-range reads still occupy a slot so ordering and latency hold.
                    rd_cnt <= rd_cnt + 32'd1;
                    mem_en <= c_in_range;
                    iss    <= '{vld: 1'b1, host: 1'b0, zero: ~c_in_range};
                    if (!c_in_range) err_rd <= 1'b1;
                end
            end else if (host_ready) begin
                mem_addr  <= host_addr;
                mem_wdata <= host_wdata;
                mem_en    <= h_in_range;
                mem_we    <= host_we & h_in_range;
                if (!host_we) iss <= '{vld: 1'b1, host: 1'b1, zero: ~h_in_range};
            end

            pipe[0] <= iss;
            for (int i = 1; i <= MEM_LAT; i++) pipe[i] <= pipe[i-1];

            valid_extmem <= pipe[MEM_LAT].vld & ~pipe[MEM_LAT].host;
            host_rvalid  <= pipe[MEM_LAT].vld & pipe[MEM_LAT].host;
            if (pipe[MEM_LAT].vld && !pipe[MEM_LAT].host) data_extmem <= rsp_data;
            if (pipe[MEM_LAT].vld && pipe[MEM_LAT].host)  host_rdata  <= rsp_data;
        end
    end

endmodule
